bp_update_ctrl: RTL

Controller that sequences the branch history table's single write port and owns the speculative branch history register (BHR). It accepts up to two branch resolutions per cycle from the execute stage, buffers them, and drains one update per cycle into the predictor's `wr_en`/`wr_taken`/`wr_index` port. It supplies `rd_bhr` to the predictor on the fetch side, shifts it on predicted branches, and repairs it on mispredictions.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bht_update_fifo.sv | 73 +++++++
 rtl/bp_update_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor update path.
// The BHT size macro is given a default here so that every file compiled
// after this package sees a consistent table size.
`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 64
`endif

package bp_pkg;

    // Number of branch resolutions the execute stage can deliver per cycle.
    localparam int BP_NUM_RES   = 2;

    // Default table geometry derived from the build-wide size macro.
    localparam int BP_DEPTH     = `BRANCH_HISTORY_TABLE_SIZE;
    localparam int BP_LOG_DEPTH = $clog2(BP_DEPTH);

    // BHT index (and BHR) type for the default table size.
    typedef logic [BP_LOG_DEPTH-1:0] BHT_IDX;

    // One pending BHT counter update: direction plus table index.
    typedef struct packed {
        logic   taken;
        BHT_IDX index;
    } bht_update_t;

endpackage

// File: rtl/bht_update_fifo.sv
// Two-in / one-out circular FIFO holding pending BHT updates.
// Each entry is {taken, index}. Up to two entries are written per cycle
// (slot 0 ahead of slot 1) and one is retired every cycle the FIFO is
// non-empty. Pointers wrap modulo Q_DEPTH (power of two). Only the control
// state (pointers, count) is reset; storage holds data and is left unreset,
// since it is never observed while the count is zero.
module bht_update_fifo #(
    parameter int Q_DEPTH = 8,
    parameter int IDX_W   = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           push_i,
    input  logic [1:0][IDX_W:0]  push_data_i,
    output logic                 valid_o,
    output logic [IDX_W:0]       head_o,
    output logic                 ready_o
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W:0]   mem_q [Q_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [PTR_W-1:0] tail_slot1;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pop;

    // The write port drains one entry whenever anything is queued.
    assign pop        = (count_q != '0);
    // Slot 1 lands right behind slot 0 when both push, otherwise at the tail.
    assign tail_slot1 = tail_q + PTR_W'(push_i[0]);

    // Next pointer and occupancy values; power-of-two depth gives free wrap.
    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push_i[0]) + PTR_W'(push_i[1]);
        count_d = count_q + CNT_W'(push_i[0]) + CNT_W'(push_i[1]) - CNT_W'(pop);
    end

    // Control state: pointers and count, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: written in arrival order, no reset needed.
    always_ff @(posedge clock) begin
        if (push_i[0]) begin
            mem_q[tail_q] <= push_data_i[0];
        end
        if (push_i[1]) begin
            mem_q[tail_slot1] <= push_data_i[1];
        end
    end

    assign valid_o = pop;
    assign head_o  = mem_q[head_q];
    // Room for a worst-case dual push, judged on the registered count only.
    assign ready_o = (count_q <= CNT_W'(Q_DEPTH - 2));

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor update controller.
// Owns the speculative branch history register (shifted by fetch, repaired
// on mispredicts) and serialises up to two resolutions per cycle onto the
// BHT's single write port through a small update queue.
// Optional feature: define BP_UPDATE_BYPASS_EN to let a resolution arriving
// at an empty queue drive the write port in the same cycle.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH   = `BRANCH_HISTORY_TABLE_SIZE,
    parameter int Q_DEPTH = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  fetch_valid,
    input  logic                                  fetch_pred,
    input  logic [BP_NUM_RES-1:0]                 res_valid,
    input  logic [BP_NUM_RES-1:0]                 res_taken,
    input  logic [BP_NUM_RES-1:0][$clog2(DEPTH)-1:0] res_index,
    input  logic [BP_NUM_RES-1:0][$clog2(DEPTH)-1:0] res_bhr,
    input  logic [BP_NUM_RES-1:0]                 res_mispredict,
    output logic                                  res_ready,
    output logic [$clog2(DEPTH)-1:0]              rd_bhr,
    output logic                                  wr_en,
    output logic                                  wr_taken,
    output logic [$clog2(DEPTH)-1:0]              wr_index,
    output logic                                  overflow_err
);

    localparam int LOG_DEPTH = $clog2(DEPTH);

    logic [LOG_DEPTH-1:0]                 bhr_q;
    logic [LOG_DEPTH-1:0]                 bhr_d;
    logic                                 err_q;
    logic                                 err_d;
    logic [BP_NUM_RES-1:0]                enq;
    logic [BP_NUM_RES-1:0][LOG_DEPTH:0]   enq_data;
    logic                                 byp_en;
    logic                                 byp_taken;
    logic [LOG_DEPTH-1:0]                 byp_index;
    logic                                 fifo_valid;
    logic [LOG_DEPTH:0]                   fifo_head;
    logic                                 fifo_ready;
    logic                                 unused_msbs;

    // The history shift discards the oldest bit of each source.
    assign unused_msbs = ^{bhr_q[LOG_DEPTH-1], res_bhr[0][LOG_DEPTH-1],
                           res_bhr[1][LOG_DEPTH-1]};

    // Pack each resolution as {taken, index} for the queue.
    assign enq_data[0] = {res_taken[0], res_index[0]};
    assign enq_data[1] = {res_taken[1], res_index[1]};

    // Next BHR: fetch shift, overridden by a repair; port 0 is older so it
    // is evaluated last and wins when both ports mispredict.
    always_comb begin
        bhr_d = bhr_q;
        if (fetch_valid) begin
            bhr_d = {bhr_q[LOG_DEPTH-2:0], fetch_pred};
        end
        for (int i = BP_NUM_RES - 1; i >= 0; i--) begin
            if (res_valid[i] && res_mispredict[i]) begin
                bhr_d = {res_bhr[i][LOG_DEPTH-2:0], res_taken[i]};
            end
        end
    end

    // Decide which resolutions enter the queue and which (if any) bypass it.
    // Requests seen while not ready are dropped here.
    always_comb begin
        enq       = res_ready ? res_valid : '0;
        byp_en    = 1'b0;
        byp_taken = 1'b0;
        byp_index = '0;
`ifdef BP_UPDATE_BYPASS_EN
        if (!fifo_valid) begin
            if (res_valid[0]) begin
                byp_en    = 1'b1;
                byp_taken = res_taken[0];
                byp_index = res_index[0];
                enq[0]    = 1'b0;
            end else if (res_valid[1]) begin
                byp_en    = 1'b1;
                byp_taken = res_taken[1];
                byp_index = res_index[1];
                enq[1]    = 1'b0;
            end
        end
`endif
    end

    // Overflow is sticky until reset.
    assign err_d = err_q | ((|res_valid) & ~res_ready);

    // BHR and error flag state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bhr_q <= '0;
            err_q <= 1'b0;
        end else begin
            bhr_q <= bhr_d;
            err_q <= err_d;
        end
    end

    bht_update_fifo #(
        .Q_DEPTH (Q_DEPTH),
        .IDX_W   (LOG_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (enq),
        .push_data_i (enq_data),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .ready_o     (fifo_ready)
    );

    assign res_ready    = fifo_ready;
    assign rd_bhr       = bhr_q;
    assign overflow_err = err_q;

    // Write port: bypass if active, otherwise the queue head; held at zero
    // when idle so stale storage never reaches the predictor.
    assign wr_en    = byp_en | fifo_valid;
    assign wr_taken = byp_en ? byp_taken :
                      (fifo_valid ? fifo_head[LOG_DEPTH] : 1'b0);
    assign wr_index = byp_en ? byp_index :
                      (fifo_valid ? fifo_head[LOG_DEPTH-1:0] : '0);

endmodule
